// File: rtl/decode_stage_pipelined.sv
// MIPS decode stage: register file with write-first bypass, branch operand forwarding,
// branch/jump resolution back to fetch, and the ID/EX pipeline register.
module decode_stage_pipelined #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int INSTR_WIDTH   = 32,
    parameter int RF_ADDR_WIDTH = 5,
    parameter int ZERO_REG      = 1
) (
    input  logic                     i_CLK,
    input  logic                     i_RST,
    input  logic [INSTR_WIDTH-1:0]   i_InstrD,
    input  logic [ADDRESS_WIDTH-1:0] i_PCPlus4D,
    input  logic                     i_ValidD,
    input  logic [2:0]               i_BranchCondD,
    input  logic [1:0]               i_ForwardAD,
    input  logic [1:0]               i_ForwardBD,
    input  logic [DATA_WIDTH-1:0]    i_ALUOutM,
    input  logic [DATA_WIDTH-1:0]    i_ResultW,
    input  logic [RF_ADDR_WIDTH-1:0] i_WriteRegW,
    input  logic                     i_RegWriteW,
    input  logic                     i_StallE,
    input  logic                     i_FlushE,
    output logic                     o_PCSrcD,
    output logic [ADDRESS_WIDTH-1:0] o_PCNextD,
    output logic [DATA_WIDTH-1:0]    o_SrcAE,
    output logic [DATA_WIDTH-1:0]    o_SrcBE,
    output logic [DATA_WIDTH-1:0]    o_SignImmE,
    output logic [RF_ADDR_WIDTH-1:0] o_RsE,
    output logic [RF_ADDR_WIDTH-1:0] o_RtE,
    output logic [RF_ADDR_WIDTH-1:0] o_RdE,
    output logic [ADDRESS_WIDTH-1:0] o_PCPlus4E,
    output logic                     o_ValidE
);

    localparam int RF_DEPTH = 1 << RF_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]    rf_r [RF_DEPTH];
    logic [RF_ADDR_WIDTH-1:0] rs_s, rt_s, rd_s;
    logic [15:0]              imm_s;
    logic [DATA_WIDTH-1:0]    sign_imm_s;
    logic                     we_s;
    logic [DATA_WIDTH-1:0]    rd_a_s, rd_b_s, cmp_a_s, cmp_b_s;
    logic [ADDRESS_WIDTH-1:0] branch_target_s, jump_target_s, jr_target_s, target_s;
    logic                     taken_s, pc_src_s;
    logic                     cmp_a_zero_s;
    logic                     unused_s;

    assign rs_s       = RF_ADDR_WIDTH'(i_InstrD[25:21]);
    assign rt_s       = RF_ADDR_WIDTH'(i_InstrD[20:16]);
    assign rd_s       = RF_ADDR_WIDTH'(i_InstrD[15:11]);
    assign imm_s      = i_InstrD[15:0];
    assign sign_imm_s = {{(DATA_WIDTH-16){imm_s[15]}}, imm_s};
    assign unused_s   = ^i_InstrD[INSTR_WIDTH-1:26];

    // Register 0 is hard-wired when ZERO_REG is set, so its writes are dropped here
    assign we_s = i_RegWriteW & ((ZERO_REG != 1) | (|i_WriteRegW));

    assign rd_a_s = ((ZERO_REG == 1) && (rs_s == '0)) ? '0 :
                    (we_s && (rs_s == i_WriteRegW))   ? i_ResultW : rf_r[rs_s];
    assign rd_b_s = ((ZERO_REG == 1) && (rt_s == '0)) ? '0 :
                    (we_s && (rt_s == i_WriteRegW))   ? i_ResultW : rf_r[rt_s];

    // Register file write port; reset clears every entry
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                rf_r[i] <= '0;
            end
        end else if (we_s) begin
            rf_r[i_WriteRegW] <= i_ResultW;
        end
    end

    // Operand source selection for the branch comparator and ID/EX operands
    always_comb begin
        cmp_a_s = rd_a_s;
        cmp_b_s = rd_b_s;
        case (i_ForwardAD)
            2'b01:   cmp_a_s = i_ALUOutM;
            2'b10:   cmp_a_s = i_ResultW;
            default: cmp_a_s = rd_a_s;
        endcase
        case (i_ForwardBD)
            2'b01:   cmp_b_s = i_ALUOutM;
            2'b10:   cmp_b_s = i_ResultW;
            default: cmp_b_s = rd_b_s;
        endcase
    end

    assign branch_target_s = i_PCPlus4D + {{(ADDRESS_WIDTH-18){imm_s[15]}}, imm_s, 2'b00};
    assign jump_target_s   = ((i_PCPlus4D >> 28) << 28) | ADDRESS_WIDTH'({i_InstrD[25:0], 2'b00});
    assign jr_target_s     = ADDRESS_WIDTH'(cmp_a_s);
    assign cmp_a_zero_s    = (cmp_a_s == '0);

    // Branch/jump condition evaluation and target selection
    always_comb begin
        taken_s  = 1'b0;
        target_s = i_PCPlus4D;
        case (i_BranchCondD)
            3'b001: begin taken_s = (cmp_a_s == cmp_b_s); target_s = branch_target_s; end
            3'b010: begin taken_s = (cmp_a_s != cmp_b_s); target_s = branch_target_s; end
            3'b011: begin taken_s = cmp_a_s[DATA_WIDTH-1] | cmp_a_zero_s; target_s = branch_target_s; end
            3'b100: begin taken_s = ~cmp_a_s[DATA_WIDTH-1] & ~cmp_a_zero_s; target_s = branch_target_s; end
            3'b101: begin taken_s = 1'b1; target_s = jr_target_s; end
            3'b110: begin taken_s = 1'b1; target_s = jump_target_s; end
            default: begin taken_s = 1'b0; target_s = i_PCPlus4D; end
        endcase
    end

    assign pc_src_s  = taken_s & i_ValidD;
    assign o_PCSrcD  = pc_src_s;
    assign o_PCNextD = pc_src_s ? target_s : i_PCPlus4D;

    // ID/EX pipeline register: flush beats stall
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST || i_FlushE) begin
            o_SrcAE    <= '0;
            o_SrcBE    <= '0;
            o_SignImmE <= '0;
            o_RsE      <= '0;
            o_RtE      <= '0;
            o_RdE      <= '0;
            o_PCPlus4E <= '0;
            o_ValidE   <= 1'b0;
        end else if (!i_StallE) begin
            o_SrcAE    <= cmp_a_s;
            o_SrcBE    <= cmp_b_s;
            o_SignImmE <= sign_imm_s;
            o_RsE      <= rs_s;
            o_RtE      <= rt_s;
            o_RdE      <= rd_s;
            o_PCPlus4E <= i_PCPlus4D;
            o_ValidE   <= i_ValidD;
        end
    end

endmodule

// File: doc/decode_stage_pipelined.md
Name: decode_stage_pipelined

Overview:
- Parametrised next-generation decode stage for the pipelined MIPS core.
- Contains a register file of 2^RF_ADDR_WIDTH entries with write-first bypass, 3-source forwarding for branch operands, and multi-mode branch/jump resolution (beq, bne, blez, bgtz, j, jr).
- Includes the ID/EX pipeline register with stall and flush, so its outputs feed the execute stage directly.
- Sits between the IF/ID register and the execute stage. Its redirect outputs go back to fetch.

Parameters:
- DATA_WIDTH, 32, register and operand width.
- ADDRESS_WIDTH, 32, PC width; must be >= 28.
- INSTR_WIDTH, 32, instruction width; fields use MIPS bit positions.
- RF_ADDR_WIDTH, 5, register address width; the register file has 2^RF_ADDR_WIDTH entries.
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes.

Ports:
- i_CLK  in  1  clock; all state changes on the rising edge.
- i_RST  in  1  asynchronous, active-high reset.
- i_InstrD  in  INSTR_WIDTH  decode-stage instruction.
- i_PCPlus4D  in  ADDRESS_WIDTH  PC+4 of the decode instruction.
- i_ValidD  in  1  decode slot holds a real instruction.
- i_BranchCondD  in  3  000 none, 001 beq, 010 bne, 011 blez, 100 bgtz, 101 jr, 110 j, 111 reserved (treated as none).
- i_ForwardAD  in  2  operand A source: 00 register file, 01 i_ALUOutM, 10 i_ResultW, 11 register file.
- i_ForwardBD  in  2  operand B source, same encoding as i_ForwardAD.
- i_ALUOutM  in  DATA_WIDTH  memory-stage ALU result.
- i_ResultW  in  DATA_WIDTH  writeback data.
- i_WriteRegW  in  RF_ADDR_WIDTH  writeback register address.
- i_RegWriteW  in  1  writeback enable.
- i_StallE  in  1  hold the ID/EX register.
- i_FlushE  in  1  load a bubble into the ID/EX register.
- o_PCSrcD  out  1  redirect fetch (branch/jump taken); combinational.
- o_PCNextD  out  ADDRESS_WIDTH  redirect target; equals i_PCPlus4D when o_PCSrcD=0; combinational.
- o_SrcAE, o_SrcBE  out  DATA_WIDTH  registered forwarded operands.
- o_SignImmE  out  DATA_WIDTH  registered sign-extended imm[15:0].
- o_RsE, o_RtE, o_RdE  out  RF_ADDR_WIDTH  registered instr[25:21], [20:16], [15:11], truncated to RF_ADDR_WIDTH.
- o_PCPlus4E  out  ADDRESS_WIDTH  registered PC+4.
- o_ValidE  out  1  registered valid.

Behaviour:
Reset:
- i_RST high clears every register-file entry and every ID/EX output to 0 (o_ValidE=0) immediately, without waiting for a clock edge.
- Reset asserted mid-stall or mid-write is still a full clear; the pending write is lost.

Register file:
- Two combinational read ports, addressed by Rs and Rt; one synchronous write port.
- Write occurs when i_RegWriteW=1, and also i_WriteRegW!=0 when ZERO_REG=1.
- Write-first bypass: if a read address equals i_WriteRegW with the write enabled, that read returns i_ResultW in the same cycle.
- With ZERO_REG=1, address 0 always reads 0, including under bypass.

Forwarding:
- CmpA and CmpB are selected per i_ForwardAD and i_ForwardBD.

Branch resolution (combinational, zero latency):
- BranchTarget = i_PCPlus4D + (SignImm << 2), truncated to ADDRESS_WIDTH (wrap-around).
- JumpTarget = {i_PCPlus4D[ADDRESS_WIDTH-1:28], instr[25:0], 2'b00}.
- jr target = CmpA truncated or zero-extended to ADDRESS_WIDTH.
- Taken conditions:
  - beq: CmpA==CmpB.
  - bne: CmpA!=CmpB.
  - blez: CmpA is signed <= 0.
  - bgtz: CmpA is signed > 0.
  - jr and j: always taken.
- o_PCSrcD = taken & i_ValidD.
- o_PCNextD = the target when taken, otherwise i_PCPlus4D.

ID/EX register, rising edge, priority order:
1. i_FlushE=1: all outputs load 0 and o_ValidE=0. Flush wins over stall.
2. Else i_StallE=1: all outputs hold.
3. Else load CmpA, CmpB, SignImm, Rs/Rt/Rd, i_PCPlus4D, and i_ValidD.

The register-file write happens regardless of i_StallE or i_FlushE.

Test Plan:
1. Reset: assert i_RST asynchronously mid-cycle -> all ID/EX outputs are 0 immediately; after release, reading r5 returns 0.
2. Write-first bypass: write r3=0x0000_00AA (i_RegWriteW=1, i_WriteRegW=3) while i_InstrD has rs=3 and i_ForwardAD=00 -> CmpA=0xAA in the same cycle and o_SrcAE=0xAA after the edge. Writing r0=0xFFFF_FFFF -> reading r0 returns 0.
3. beq/bne with forwarding: r1=7, i_ALUOutM=7, i_ForwardBD=01, rs=1, rt=2, imm=0xFFFF, i_PCPlus4D=0x100.
   - beq -> o_PCSrcD=1, o_PCNextD=0x0FC.
   - bne -> o_PCSrcD=0, o_PCNextD=0x100.
   - Same beq case with i_ValidD=0 -> o_PCSrcD=0.
4. blez/bgtz on CmpA values 0x8000_0000, 0, and 1:
   - blez taken for 0x8000_0000 and 0, not for 1.
   - bgtz taken only for 1.
5. j/jr: i_PCPlus4D=0xA000_0004, instr[25:0]=0x0000010, j -> o_PCNextD=0xA000_0040. jr with CmpA=0x0040_0000 -> o_PCNextD=0x0040_0000.
6. Stall/flush: load one instruction, then assert i_StallE for 2 cycles -> outputs hold. Then assert i_StallE and i_FlushE together -> all ID/EX outputs are 0 and o_ValidE=0 on the next edge.
